hcsr04_ranger: RTL and testbench

Measurement core behind the HCRS04 AXI4-Lite register bank. It generates the HC-SR04 trigger pulse and times the echo pulse in microseconds. It converts the echo width to millimetres and presents result, status and done-strobe to the slave registers. Single-shot or continuous operation is selected from the control register.

---
 rtl/hcsr04_ranger.sv | 117 +++++++++++
 tb/tb_hcsr04_ranger.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: HC-SR04 trigger generator, echo timer (us) and mm converter
// Optional echo deglitch filter enabled by defining HCSR04_DEGLITCH_EN.
module hcsr04_ranger #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 60000,
  parameter int US_W        = 16
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            start_i,
  input  logic            cont_i,
  input  logic            echo_i,
  output logic            trig_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic [US_W-1:0] echo_us_o,
  output logic [US_W-1:0] dist_mm_o
);
  localparam int CYC  = CLK_FREQ_HZ / 1000000;
  localparam int PW   = $clog2(CYC);
  localparam int CMAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HCYC = HOLDOFF_US * CYC;
  localparam int HW   = $clog2(HCYC + 1);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  state_t st, nx;
  logic s1, s2, e_lvl, e_q, rise, fall, tick, enter_trig, cont_q, arm;
  logic [PW-1:0] pre;
  logic [CW-1:0] cnt, w;
  logic [HW-1:0] h;
  // two-flop synchronizer and edge-detector history
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) {s1, s2, e_q} <= '0;
    else {s1, s2, e_q} <= {echo_i, s1, e_lvl};
`ifdef HCSR04_DEGLITCH_EN
  logic [2:0] g;
  logic filt;
  // level follows the synchronized echo only after 8 consecutive differing samples
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) {g, filt} <= '0;
    else if (s2 == filt) g <= '0;
    else if (g == 3'd7) {g, filt} <= {3'd0, s2};
    else g <= g + 3'd1;
  assign e_lvl = filt;
`else
  assign e_lvl = s2;
`endif
  assign rise = e_lvl & ~e_q;
  assign fall = ~e_lvl & e_q;
  assign tick = pre == PW'(CYC - 1);
  assign enter_trig = nx == TRIG && st != TRIG;
  assign w = cnt + CW'(tick);
  // microsecond prescaler, realigned on trigger start and on a valid echo rise
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) pre <= '0;
    else pre <= (enter_trig || (st == WAIT_RISE && rise) || tick) ? '0 : pre + PW'(1);
  // per-state microsecond counter, cleared on every state change, saturating
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) cnt <= '0;
    else if (st != nx) cnt <= '0;
    else if (tick && cnt != CW'(CMAX)) cnt <= cnt + CW'(1);
  // holdoff cycle counter measured from trigger fall
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) h <= '0;
    else if (st == TRIG) h <= '0;
    else if (h != HW'(HCYC)) h <= h + HW'(1);
  // continuous-mode arm: remembers a rising cont_i until a trigger starts
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) {cont_q, arm} <= '0;
    else {cont_q, arm} <= {cont_i, cont_i & ~enter_trig & (arm | ~cont_q)};
  // state register
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) st <= IDLE;
    else st <= nx;
  // next-state logic
  always_comb begin
    nx = st;
    case (st)
      IDLE:      nx = (start_i || arm) ? TRIG : IDLE;
      TRIG:      nx = (tick && cnt == CW'(TRIG_US - 1)) ? WAIT_RISE : TRIG;
      WAIT_RISE: nx = rise ? MEASURE : (tick && cnt == CW'(TIMEOUT_US - 1)) ? HOLDOFF : WAIT_RISE;
      MEASURE:   nx = (fall || (tick && cnt == CW'(TIMEOUT_US - 1))) ? HOLDOFF : MEASURE;
      HOLDOFF:   nx = (h >= HW'(HCYC - 1)) ? (cont_i ? TRIG : IDLE) : HOLDOFF;
      default:   nx = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    trig_o = st == TRIG;
    busy_o = st != IDLE;
  end
  // result registers and done strobe, all updated together
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      {done_o, timeout_o} <= '0;
      echo_us_o <= '0;
      dist_mm_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (st == WAIT_RISE && nx == HOLDOFF) begin
        {done_o, timeout_o} <= 2'b11;
        echo_us_o <= '0;
        dist_mm_o <= '0;
      end else if (st == MEASURE && fall) begin
        {done_o, timeout_o} <= 2'b10;
        echo_us_o <= US_W'(w);
        dist_mm_o <= US_W'((32'(w) * 32'd11253) >> 16);
      end else if (st == MEASURE && nx == HOLDOFF) begin
        {done_o, timeout_o} <= 2'b11;
        echo_us_o <= US_W'(TIMEOUT_US);
        dist_mm_o <= '1;
      end
    end
endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: directed and randomized checks of hcsr04_ranger against a result model
module tb_hcsr04_ranger;
  localparam int CLK = 4000000, CYC = 4, TRIG = 10, TMO = 400, HOLD = 500, UW = 16;
`ifdef HCSR04_DEGLITCH_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif
  logic ACLK = 0, ARESETN = 0, start_i = 0, cont_i = 0, echo_i = 0;
  logic trig_o, busy_o, done_o, timeout_o;
  logic [UW-1:0] echo_us_o, dist_mm_o;
  hcsr04_ranger #(.CLK_FREQ_HZ(CLK), .TRIG_US(TRIG), .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD), .US_W(UW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start_i(start_i), .cont_i(cont_i), .echo_i(echo_i),
    .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .echo_us_o(echo_us_o), .dist_mm_o(dist_mm_o));
  always #5 ACLK = ~ACLK;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_rise = 0, n_fall = 0, n_done = 0;
  int last_rise = 0, prev_rise = 0, last_fall = 0, last_done = 0, trig_w = 0;
  logic trig_p = 0;
  // event monitor sampled on the falling edge
  always @(negedge ACLK) begin
    cyc++;
    if (trig_o && !trig_p) begin n_rise++; prev_rise = last_rise; last_rise = cyc; end
    if (!trig_o && trig_p) begin n_fall++; last_fall = cyc; trig_w = cyc - last_rise; end
    if (done_o) begin n_done++; last_done = cyc; end
    trig_p = trig_o;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask
  task automatic pulse_start();
    start_i = 1;
    tick(1);
    start_i = 0;
  endtask
  task automatic wait_fall(input string tag);
    int f0 = n_fall;
    for (int i = 0; i < (TRIG + HOLD + 40) * CYC && n_fall == f0; i++) @(posedge ACLK);
    #1;
    chk({tag, ".trig_fall_seen"}, n_fall != f0, 1);
  endtask
  task automatic wait_done(input string tag);
    int d0 = n_done;
    for (int i = 0; i < (TMO + 40) * CYC && n_done == d0; i++) @(posedge ACLK);
    #1;
    chk({tag, ".done_seen"}, n_done != d0, 1);
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < (HOLD + 40) * CYC && busy_o; i++) @(posedge ACLK);
    #1;
    chk({tag, ".idle"}, busy_o, 0);
  endtask
  // expected result from echo width in us (0 = no echo, >= TMO = stuck/too long)
  function automatic void model(input int w, output int to, output int us, output int mm);
    if (w == 0) begin to = 1; us = 0; mm = 0; end
    else if (w >= TMO) begin to = 1; us = TMO; mm = (1 << UW) - 1; end
    else begin to = 0; us = w; mm = ((w * 11253) >> 16) & ((1 << UW) - 1); end
  endfunction
  task automatic check_result(input string tag, input int w);
    int to, us, mm;
    model(w, to, us, mm);
    chk({tag, ".timeout"}, timeout_o, to);
    chk({tag, ".echo_us"}, echo_us_o, us);
    chk({tag, ".dist_mm"}, dist_mm_o, mm);
  endtask
  task automatic echo_pulse(input string tag, input int dly, input int w);
    int e0;
    tick(dly * CYC);
    if (w > 0) begin
      echo_i = 1;
      e0 = cyc + 1;
      if (w < TMO) begin tick(w * CYC); echo_i = 0; e0 = cyc + 1; end
    end
    wait_done(tag);
    if (w == 0) chk({tag, ".wait_timeout_time"}, last_done - last_fall, TMO * CYC);
    else if (w >= TMO) chk({tag, ".meas_timeout_window"}, (last_done - e0 >= TMO * CYC) && (last_done - e0 <= TMO * CYC + LAT + 2), 1);
    else chk({tag, ".done_latency"}, last_done - e0, LAT);
    echo_i = 0;
    check_result(tag, w);
  endtask
  task automatic shot(input string tag, input int dly, input int w, input bit dbl);
    int d0 = n_done, r0 = n_rise;
    pulse_start();
    wait_fall(tag);
    chk({tag, ".trig_width"}, trig_w, TRIG * CYC);
    if (dbl) pulse_start();
    echo_pulse(tag, dly, w);
    wait_idle(tag);
    chk({tag, ".one_done"}, n_done - d0, 1);
    chk({tag, ".one_trig"}, n_rise - r0, 1);
  endtask
  initial begin
    int d0, r0, w;
    tick(3);
    chk("rst.trig", trig_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.timeout", timeout_o, 0);
    chk("rst.echo_us", echo_us_o, 0);
    chk("rst.dist_mm", dist_mm_o, 0);
    ARESETN = 1;
    tick(3);
    shot("w_min", 5, 1, 0);
    shot("w_100", 12, 100, 0);
    shot("w_max", 3, TMO - 1, 0);
    shot("no_echo", 1, 0, 0);
    shot("stuck", 7, TMO, 0);
    shot("busy_start", 10, $urandom_range(1, TMO - 1), 1);
    for (int i = 0; i < 4; i++) shot("rand", $urandom_range(1, 30), $urandom_range(1, TMO - 1), 0);
    d0 = n_done;
    pulse_start();
    tick(3 * CYC);
    echo_i = 1;
    wait_fall("pre_high");
    tick(50 * CYC);
    echo_i = 0;
    echo_pulse("pre_high", 20, 30);
    wait_idle("pre_high");
    chk("pre_high.one_done", n_done - d0, 1);
`ifdef HCSR04_DEGLITCH_EN
    pulse_start();
    wait_fall("glitch");
    tick(10 * CYC);
    echo_i = 1;
    tick(5);
    echo_i = 0;
    echo_pulse("glitch", 1, 0);
    wait_idle("glitch");
`endif
    d0 = n_done;
    cont_i = 1;
    for (int s = 0; s < 3; s++) begin
      wait_fall("cont");
      if (s > 0) chk("cont.trig_period", last_rise - prev_rise, (TRIG + HOLD) * CYC);
      if (s == 2) cont_i = 0;
      w = $urandom_range(1, TMO - 1);
      echo_pulse("cont", $urandom_range(1, 30), w);
    end
    wait_idle("cont");
    r0 = n_rise;
    tick((HOLD + 20) * CYC);
    chk("cont.no_retrig", n_rise - r0, 0);
    chk("cont.done_count", n_done - d0, 3);
    pulse_start();
    tick(5);
    chk("rst_trig.pre", trig_o, 1);
    ARESETN = 0;
    #1;
    chk("rst_trig.trig", trig_o, 0);
    chk("rst_trig.busy", busy_o, 0);
    tick(2);
    ARESETN = 1;
    tick(2);
    pulse_start();
    wait_fall("rst_meas");
    tick(5 * CYC);
    echo_i = 1;
    tick(20 * CYC);
    chk("rst_meas.busy_pre", busy_o, 1);
    ARESETN = 0;
    #1;
    chk("rst_meas.trig", trig_o, 0);
    chk("rst_meas.busy", busy_o, 0);
    chk("rst_meas.done", done_o, 0);
    chk("rst_meas.timeout", timeout_o, 0);
    chk("rst_meas.echo_us", echo_us_o, 0);
    chk("rst_meas.dist_mm", dist_mm_o, 0);
    echo_i = 0;
    tick(3);
    ARESETN = 1;
    tick(3);
    shot("post_rst", $urandom_range(1, 30), $urandom_range(1, TMO - 1), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
